// File: rtl/la_pkg.sv
// Shared logic-analyzer package: dump FSM state type, channel codes and the
// default sample RAM geometry shared with the capture controller.
// DUMP_CRC_EN adds the checksum state to dump_state_t.
package la_pkg;

  localparam int DEF_ENTRIES = 384;
  localparam int DEF_LOG2    = 9;

  localparam logic [2:0] CH1 = 3'd1;
  localparam logic [2:0] CH2 = 3'd2;
  localparam logic [2:0] CH3 = 3'd3;
  localparam logic [2:0] CH4 = 3'd4;
  localparam logic [2:0] CH5 = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_SEND,
`ifdef DUMP_CRC_EN
    ST_WAIT,
    ST_CRC
`else
    ST_WAIT
`endif
  } dump_state_t;

  function automatic logic chan_valid(input logic [2:0] chan);
    return (chan >= CH1) && (chan <= CH5);
  endfunction

endpackage

// File: rtl/dump_addr_gen.sv
// Modulo-ENTRIES read address counter with a sample counter that flags the
// last sample of a dump. Load takes priority over increment.
module dump_addr_gen #(
  parameter int ENTRIES = 384,
  parameter int LOG2    = 9
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [LOG2-1:0] load_addr,
  input  logic            inc,
  output logic [LOG2-1:0] addr,
  output logic            last
);

  localparam logic [LOG2-1:0] TOP = LOG2'(ENTRIES - 1);

  logic [LOG2-1:0] addr_q, addr_d;
  logic [LOG2-1:0] cnt_q, cnt_d;

  // next address / count; wrap is explicit since ENTRIES need not be a power of two
  always_comb begin
    addr_d = addr_q;
    cnt_d  = cnt_q;
    if (load) begin
      addr_d = load_addr;
      cnt_d  = '0;
    end else if (inc) begin
      addr_d = (addr_q == TOP) ? '0 : addr_q + 1'b1;
      cnt_d  = cnt_q + 1'b1;
    end
  end

  // address and count registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      cnt_q  <= '0;
    end else begin
      addr_q <= addr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign addr = addr_q;
  assign last = (cnt_q == TOP);

endmodule

// File: rtl/dump_ctrl.sv
// Streams one channel's sample buffer, oldest first, to the UART transmitter.
// Optional DUMP_CRC_EN appends a two's-complement checksum byte.
//
// state | meaning
// IDLE  | waiting for a dump command
// READ  | RAM read latency cycle
// SEND  | capture RAM byte into tx_data, request transmit
// WAIT  | waiting for UART tx_done
// CRC   | send checksum byte and wait for its tx_done (DUMP_CRC_EN only)
module dump_ctrl
  import la_pkg::*;
#(
  parameter int ENTRIES = DEF_ENTRIES,
  parameter int LOG2    = DEF_LOG2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            dump,
  input  logic [2:0]      dump_chan,
  input  logic [LOG2-1:0] waddr,
  input  logic [7:0]      rdata_ch1,
  input  logic [7:0]      rdata_ch2,
  input  logic [7:0]      rdata_ch3,
  input  logic [7:0]      rdata_ch4,
  input  logic [7:0]      rdata_ch5,
  input  logic            tx_done,
  output logic [LOG2-1:0] raddr,
  output logic [7:0]      tx_data,
  output logic            trmt,
  output logic            busy,
  output logic            dump_done,
  output logic            dump_err
);

  dump_state_t state_q, state_d;
  logic [2:0]  chan_q, chan_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        trmt_q, trmt_d;
  logic        busy_q, busy_d;
  logic        dump_done_q, dump_done_d;
  logic        dump_err_q, dump_err_d;
  logic        addr_load, addr_inc, addr_last;
  logic [7:0]  rdata_sel;
`ifdef DUMP_CRC_EN
  logic [7:0]  sum_q, sum_d;
  logic        crc_sent_q, crc_sent_d;
`endif

  dump_addr_gen #(.ENTRIES(ENTRIES), .LOG2(LOG2)) u_addr (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (addr_load),
    .load_addr (waddr),
    .inc       (addr_inc),
    .addr      (raddr),
    .last      (addr_last)
  );

  // select the latched channel's RAM output
  always_comb begin
    rdata_sel = 8'h00;
    case (chan_q)
      CH1:     rdata_sel = rdata_ch1;
      CH2:     rdata_sel = rdata_ch2;
      CH3:     rdata_sel = rdata_ch3;
      CH4:     rdata_sel = rdata_ch4;
      CH5:     rdata_sel = rdata_ch5;
      default: rdata_sel = 8'h00;
    endcase
  end

  // next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    chan_d      = chan_q;
    tx_data_d   = tx_data_q;
    trmt_d      = 1'b0;
    busy_d      = busy_q;
    dump_done_d = 1'b0;
    dump_err_d  = 1'b0;
    addr_load   = 1'b0;
    addr_inc    = 1'b0;
`ifdef DUMP_CRC_EN
    sum_d       = sum_q;
    crc_sent_d  = crc_sent_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (dump) begin
          if (chan_valid(dump_chan)) begin
            chan_d    = dump_chan;
            addr_load = 1'b1;
            busy_d    = 1'b1;
            state_d   = ST_READ;
`ifdef DUMP_CRC_EN
            sum_d     = 8'h00;
`endif
          end else begin
            dump_err_d = 1'b1;
          end
        end
      end
      ST_READ: state_d = ST_SEND;
      ST_SEND: begin
        tx_data_d = rdata_sel;
        trmt_d    = 1'b1;
        state_d   = ST_WAIT;
`ifdef DUMP_CRC_EN
        sum_d     = sum_q + rdata_sel;
`endif
      end
      ST_WAIT: begin
        if (tx_done) begin
          if (addr_last) begin
`ifdef DUMP_CRC_EN
            crc_sent_d  = 1'b0;
            state_d     = ST_CRC;
`else
            busy_d      = 1'b0;
            dump_done_d = 1'b1;
            state_d     = ST_IDLE;
`endif
          end else begin
            addr_inc = 1'b1;
            state_d  = ST_READ;
          end
        end
      end
`ifdef DUMP_CRC_EN
      ST_CRC: begin
        // first cycle issues the checksum; tx_done only counts after that
        if (!crc_sent_q) begin
          tx_data_d  = 8'h00 - sum_q;
          trmt_d     = 1'b1;
          crc_sent_d = 1'b1;
        end else if (tx_done) begin
          busy_d      = 1'b0;
          dump_done_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      chan_q      <= CH1;
      tx_data_q   <= 8'h00;
      trmt_q      <= 1'b0;
      busy_q      <= 1'b0;
      dump_done_q <= 1'b0;
      dump_err_q  <= 1'b0;
`ifdef DUMP_CRC_EN
      sum_q       <= 8'h00;
      crc_sent_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      chan_q      <= chan_d;
      tx_data_q   <= tx_data_d;
      trmt_q      <= trmt_d;
      busy_q      <= busy_d;
      dump_done_q <= dump_done_d;
      dump_err_q  <= dump_err_d;
`ifdef DUMP_CRC_EN
      sum_q       <= sum_d;
      crc_sent_q  <= crc_sent_d;
`endif
    end
  end

  assign tx_data   = tx_data_q;
  assign trmt      = trmt_q;
  assign busy      = busy_q;
  assign dump_done = dump_done_q;
  assign dump_err  = dump_err_q;

endmodule

// File: tb/tb_dump_ctrl.sv
// Scoreboard bench for dump_ctrl: a RAM/UART model drives the DUT, the
// stimulus pushes the expected byte/address stream, a monitor checks it.
module tb_dump_ctrl;
  import la_pkg::*;

  localparam int N  = DEF_ENTRIES;
  localparam int AW = DEF_LOG2;

  logic          clk, rst_n, dump, tx_done;
  logic [2:0]    dump_chan;
  logic [AW-1:0] waddr, raddr;
  logic [7:0]    rdata_ch1, rdata_ch2, rdata_ch3, rdata_ch4, rdata_ch5, tx_data;
  logic          trmt, busy, dump_done, dump_err;

  dump_ctrl #(.ENTRIES(N), .LOG2(AW)) dut (
    .clk(clk), .rst_n(rst_n), .dump(dump), .dump_chan(dump_chan), .waddr(waddr),
    .rdata_ch1(rdata_ch1), .rdata_ch2(rdata_ch2), .rdata_ch3(rdata_ch3),
    .rdata_ch4(rdata_ch4), .rdata_ch5(rdata_ch5), .tx_done(tx_done),
    .raddr(raddr), .tx_data(tx_data), .trmt(trmt), .busy(busy),
    .dump_done(dump_done), .dump_err(dump_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [1:5][0:N-1];

  always @(posedge clk) begin
    rdata_ch1 <= mem[1][raddr];
    rdata_ch2 <= mem[2][raddr];
    rdata_ch3 <= mem[3][raddr];
    rdata_ch4 <= mem[4][raddr];
    rdata_ch5 <= mem[5][raddr];
  end

  logic [7:0] exp_bytes[$];
  int         exp_addr[$];
  int         exp_done, exp_err, bytes_seen;
  int         vectors, miscompares;
  int         dly_min, dly_max;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic unexpected(input string nm);
    vectors++;
    miscompares++;
    $display("FAIL %s: event seen, none expected at %0t", nm, $time);
  endtask

  // expected stream straight from the rules: ENTRIES bytes starting at waddr, mod ENTRIES
  task automatic push_expected(input int chan, input int wa);
    int sum;
    int a;
    sum = 0;
    a = wa;
    for (int i = 0; i < N; i++) begin
      a = (wa + i) % N;
      exp_bytes.push_back(mem[chan][a]);
      exp_addr.push_back(a);
      sum += int'(mem[chan][a]);
    end
`ifdef DUMP_CRC_EN
    exp_bytes.push_back(8'((256 - (sum % 256)) % 256));
    exp_addr.push_back(a);
`endif
    exp_done++;
  endtask

  task automatic start_dump(input int chan, input int wa, input bit accept);
    @(negedge clk);
    dump_chan = 3'(chan);
    waddr     = AW'(wa);
    dump      = 1'b1;
    if (accept) push_expected(chan, wa);
    @(negedge clk);
    dump = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((exp_bytes.size() != 0 || exp_done != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("dump_finished_in_budget", 32'(n < budget), 1);
    @(negedge clk);
    chk("busy_idle", 32'(busy), 0);
  endtask

  task automatic wait_bytes(input int target, input int budget);
    int n;
    n = 0;
    while (bytes_seen < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("reached_byte", 32'(n < budget), 1);
  endtask

  task automatic fill_random(input int chan);
    for (int i = 0; i < N; i++) mem[chan][i] = 8'($urandom);
  endtask

  // UART model: tx_done a programmable number of cycles after each trmt
  initial begin
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && trmt) begin
        repeat ($urandom_range(dly_max, dly_min)) @(negedge clk);
        #1 tx_done = 1'b1;
        @(negedge clk);
        #1 tx_done = 1'b0;
      end
    end
  end

  // monitor: pops and compares whenever the DUT presents an output event
  initial begin
    logic [7:0] b;
    int a;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (trmt) begin
          if (exp_bytes.size() == 0) unexpected("trmt");
          else begin
            b = exp_bytes.pop_front();
            a = exp_addr.pop_front();
            chk("tx_data", 32'(tx_data), 32'(b));
            chk("raddr", 32'(raddr), 32'(a));
            chk("busy_at_trmt", 32'(busy), 1);
          end
          bytes_seen++;
        end
        if (dump_done) begin
          if (exp_done == 0) unexpected("dump_done");
          else begin
            exp_done--;
            chk("bytes_left_at_done", 32'(exp_bytes.size()), 0);
            chk("busy_at_done", 32'(busy), 0);
            chk("done_follows_tx_done", 32'(tx_done), 1);
          end
        end
        if (dump_err) begin
          if (exp_err == 0) unexpected("dump_err");
          else exp_err--;
        end
      end
    end
  end

  initial begin
    int base, wa;
    vectors = 0; miscompares = 0;
    exp_done = 0; exp_err = 0; bytes_seen = 0;
    dly_min = 10; dly_max = 10;
    dump = 1'b0; dump_chan = 3'd0; waddr = '0;
    for (int c = 1; c <= 5; c++) fill_random(c);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_raddr", 32'(raddr), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_trmt", 32'(trmt), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(dump_done), 0);
    chk("rst_err", 32'(dump_err), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // ch1 ramp from waddr 0, fixed 10-cycle UART, with start latency checks
    for (int i = 0; i < N; i++) mem[1][i] = 8'(i);
    start_dump(1, 0, 1'b1);
    chk("busy_after_dump", 32'(busy), 1);
    @(negedge clk);
    chk("trmt_not_yet", 32'(trmt), 0);
    @(negedge clk);
    chk("trmt_at_3", 32'(trmt), 1);
    wait_idle(8000);

    // ch3 from waddr 380: wrap 383 -> 0 checked through the address stream
    dly_min = 0; dly_max = 3;
    fill_random(3);
    start_dump(3, 380, 1'b1);
    wait_idle(8000);

    // invalid channels
    for (int k = 0; k < 2; k++) begin
      exp_err++;
      start_dump((k == 0) ? 0 : 6, 5, 1'b0);
      chk("dump_err_pulse", 32'(dump_err), 1);
      chk("busy_on_err", 32'(busy), 0);
      repeat (6) @(negedge clk);
      chk("no_trmt_after_err", 32'(trmt), 0);
      chk("err_consumed", 32'(exp_err), 0);
    end
    exp_err++;
    start_dump(7, 5, 1'b0);
    repeat (4) @(negedge clk);
    chk("err7_consumed", 32'(exp_err), 0);

    // second dump mid-stream is ignored
    fill_random(1);
    wa = $urandom_range(N - 1, 0);
    base = bytes_seen;
    start_dump(1, wa, 1'b1);
    wait_bytes(base + 50, 2000);
    start_dump(2, $urandom_range(N - 1, 0), 1'b0);
    wait_idle(8000);

    // reset mid-dump, then a fresh dump restarts from waddr
    fill_random(4);
    wa = $urandom_range(N - 1, 0);
    base = bytes_seen;
    start_dump(4, wa, 1'b1);
    wait_bytes(base + 100, 3000);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_trmt", 32'(trmt), 0);
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_raddr", 32'(raddr), 0);
    exp_bytes.delete();
    exp_addr.delete();
    exp_done = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    start_dump(4, wa, 1'b1);
    wait_idle(8000);

    // ch5 all ones: checksum byte 0x80 when compiled in
    for (int i = 0; i < N; i++) mem[5][i] = 8'h01;
    start_dump(5, $urandom_range(N - 1, 0), 1'b1);
    wait_idle(8000);

    // random channel/start
    fill_random(2);
    start_dump(2, $urandom_range(N - 1, 0), 1'b1);
    wait_idle(8000);

    repeat (5) @(negedge clk);
    chk("final_bytes_empty", 32'(exp_bytes.size()), 0);
    chk("final_done_count", 32'(exp_done), 0);
    chk("final_err_count", 32'(exp_err), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
